mips_mc_ctrl: RTL

- Control FSM that sequences the shared MIPS datapath over multiple cycles: one memory port, one ALU, one register file, one instruction register (IR).
- Replaces the single-cycle ControlLines decode.
- Each instruction is walked through fetch, decode, execute, memory and writeback states.
- The memory port is gated by a ready handshake; an optional retired-instruction counter is kept.

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/mips_mc_outdec.sv | 131 +++++++++++++
 rtl/mips_mc_ctrl.sv | 79 +++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multi-cycle MIPS control path.
//   - state_t   : 4-bit controller state encoding (FETCH .. JUMP, 12-15 unused)
//   - OP_*      : supported primary opcodes (IR[31:26])
//   - ALU_*     : ALUOp encodings
//   - SRCB_*    : ALUSrcB encodings
//   - PCS_*     : PCSource encodings
//   - is_retire_state : states whose exit to FETCH retires an instruction
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // Final state of every instruction class; leaving it for FETCH retires.
  function automatic logic is_retire_state(input state_t s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) ||
           (s == S_ADDIWB) || (s == S_BRANCH) || (s == S_JUMP);
  endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// mips_mc_outdec: combinational control-line and next-state decoder.
// Inputs : rst_i (forces all lines low), state_i, opcode_i, zero_i,
//          mem_ready_i (ignored when MEM_HS = 0).
// Outputs: datapath strobes/selects, next_state_o, retire_o (an
//          instruction completes on this edge), illegal_op_o.
module mips_mc_outdec
  import mips_pkg::*;
#(
  parameter int MEM_HS = 1
) (
  input  logic       rst_i,
  input  state_t     state_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_en_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       illegal_op_o,
  output logic       retire_o,
  output state_t     next_state_o
);

  logic ready;
  assign ready = (MEM_HS != 0) ? mem_ready_i : 1'b1;

  always_comb begin
    pc_en_o      = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_dst_o    = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_RT;
    alu_op_o     = ALU_ADD;
    pc_source_o  = PCS_ALU;
    illegal_op_o = 1'b0;
    next_state_o = S_FETCH;

    // Reset forces every line low even though the state reads FETCH,
    // so nothing is strobed while the controller is held.
    if (!rst_i) begin
      case (state_i)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = SRCB_FOUR;
          ir_write_o  = ready;
          pc_en_o     = ready;
          next_state_o = ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alu_src_b_o = SRCB_IMMSH;
          case (opcode_i)
            OP_LW, OP_SW:   next_state_o = S_MEMADR;
            OP_RTYPE:       next_state_o = S_EXEC;
            OP_BEQ, OP_BNE: next_state_o = S_BRANCH;
            OP_ADDI:        next_state_o = S_ADDIEX;
            OP_J:           next_state_o = S_JUMP;
            default: begin
              next_state_o = S_FETCH;
              illegal_op_o = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a_o  = 1'b1;
          alu_src_b_o  = SRCB_IMM;
          next_state_o = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          iord_o       = 1'b1;
          mem_read_o   = 1'b1;
          next_state_o = ready ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          mem_to_reg_o = 1'b1;
          reg_write_o  = 1'b1;
        end
        S_MEMWR: begin
          iord_o       = 1'b1;
          mem_write_o  = 1'b1;
          next_state_o = ready ? S_FETCH : S_MEMWR;
        end
        S_EXEC: begin
          alu_src_a_o  = 1'b1;
          alu_op_o     = ALU_FUNCT;
          next_state_o = S_ALUWB;
        end
        S_ALUWB: begin
          reg_dst_o   = 1'b1;
          reg_write_o = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALU_SUB;
          pc_source_o = PCS_ALUOUT;
          // Opcode bit 0 separates bne (000101) from beq (000100).
          pc_en_o     = opcode_i[0] ? ~zero_i : zero_i;
        end
        S_ADDIEX: begin
          alu_src_a_o  = 1'b1;
          alu_src_b_o  = SRCB_IMM;
          next_state_o = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write_o = 1'b1;
        end
        S_JUMP: begin
          pc_source_o = PCS_JUMP;
          pc_en_o     = 1'b1;
        end
        default: next_state_o = S_FETCH;
      endcase
    end
  end

  assign retire_o = !rst_i && (next_state_o == S_FETCH) && is_retire_state(state_i);

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS control FSM.
// Holds the state register and the retired-instruction counter; the
// control lines come from mips_mc_outdec.
// Ports: Clk/Rst (async active-high), Opcode, Zero, MemReady in;
//        PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
//        RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, State, IllegalOp,
//        InstrCount out.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_HS = 1,
  parameter int CNT_W  = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [5:0]       Opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCEn,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       State,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstrCount
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  mips_mc_outdec #(.MEM_HS(MEM_HS)) u_outdec (
    .rst_i        (Rst),
    .state_i      (state_q),
    .opcode_i     (Opcode),
    .zero_i       (Zero),
    .mem_ready_i  (MemReady),
    .pc_en_o      (PCEn),
    .iord_o       (IorD),
    .mem_read_o   (MemRead),
    .mem_write_o  (MemWrite),
    .ir_write_o   (IRWrite),
    .mem_to_reg_o (MemtoReg),
    .reg_dst_o    (RegDst),
    .reg_write_o  (RegWrite),
    .alu_src_a_o  (ALUSrcA),
    .alu_src_b_o  (ALUSrcB),
    .alu_op_o     (ALUOp),
    .pc_source_o  (PCSource),
    .illegal_op_o (IllegalOp),
    .retire_o     (retire),
    .next_state_o (state_d)
  );

  // Counter wraps naturally at 2^CNT_W.
  assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign State      = state_q;
  assign InstrCount = cnt_q;

endmodule
